// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    // Instruction handed back when a fetch cannot be served (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // One buffered fetch response.
    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } rsp_entry_t;

    // Result of decoding a byte address into a word slot.
    typedef struct packed {
        logic        ok;
        logic [63:0] idx;
    } word_chk_t;

    // Decode a byte address against a base and a word count. Arguments are
    // zero-extended to 64 bits by the caller. The lower bound uses the raw
    // address so a wrapped subtraction below the base cannot alias into range.
    function automatic word_chk_t word_index_ok(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input logic [63:0] depth_words);
        word_chk_t   r;
        logic [63:0] off;
        off   = addr - base;
        r.idx = off >> 2;
        r.ok  = (addr[1:0] == 2'b00) && (addr >= base) && (r.idx < depth_words);
        return r;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous FIFO of fetch responses. The head is presented
// combinationally and reads as zero while the FIFO is empty.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  rsp_entry_t    push_data,
    input  logic          pop,
    output rsp_entry_t    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    rsp_entry_t    store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end

    // Head view, forced to zero when nothing is buffered.
    always_comb begin
        head = '0;
        if (!empty) head = store[rd_ptr];
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves in-order word fetches from an
// internal array with one cycle of latency; a loader port fills the array.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                RSP_DEPTH   = 2,
    parameter logic [31:0]       NOP_INST    = NOP_INST_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_inst_o,
    output logic              rsp_err_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);

    logic [31:0]   mem [DEPTH_WORDS];
    word_chk_t     rd_chk;
    word_chk_t     wr_chk;
    rsp_entry_t    push_data;
    rsp_entry_t    head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          pop;
    logic          unused_bits;

    assign rd_chk = word_index_ok(64'(req_addr_i), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign wr_chk = word_index_ok(64'(wr_addr_i),  64'(BASE_ADDR), 64'(DEPTH_WORDS));

    // Ready comes only from registered occupancy, never from rsp_ready_i.
    assign req_ready_o = !fifo_full;
    assign rsp_valid_o = !fifo_empty;
    assign rsp_inst_o  = head.inst;
    assign rsp_err_o   = head.err;
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = rsp_valid_o && rsp_ready_i;

    // Upper index bits are zero whenever the decode reports in-range.
    assign unused_bits = ^{rd_chk.idx[63:IDX_W], wr_chk.idx[63:IDX_W], fifo_count};

    // Read the array on the accept edge; the write below lands on the same
    // edge, so a colliding fetch sees the old word.
    always_comb begin
        push_data.inst = NOP_INST;
        push_data.err  = 1'b1;
        if (rd_chk.ok) begin
            push_data.inst = mem[rd_chk.idx[IDX_W-1:0]];
            push_data.err  = 1'b0;
        end
    end

    // Loader writes; misaligned or out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_chk.ok) mem[wr_chk.idx[IDX_W-1:0]] <= wr_data_i;
    end

    imem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Directed plus randomized bench for imem_responder against a queue/array model.
module tb_imem_responder;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        rsp_ready_i;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;

    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_inst_o;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_inst;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t     q[$];
    bit [31:0] mmem [1024];

    always #5 clk_i = ~clk_i;

    imem_responder dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_inst_o(rsp_inst_o), .rsp_err_o(rsp_err_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
    );

    imem_responder #(.BASE_ADDR(32'h0000_0100)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(b_req_ready), .req_addr_i(req_addr_i),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready_i),
        .rsp_inst_o(b_rsp_inst), .rsp_err_o(b_rsp_err),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word-addressed store of 1024 words at base 0.
    function automatic bit m_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 1024);
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        exp_t e;
        bit   acc, pop;
        #1;
        chk("req_ready", req_ready_o, (q.size() < 2));
        chk("rsp_valid", rsp_valid_o, (q.size() > 0));
        if (q.size() > 0) begin
            chk("rsp_inst", rsp_inst_o, q[0].inst);
            chk("rsp_err", rsp_err_o, q[0].err);
        end
        acc    = req_valid_i && (q.size() < 2);
        pop    = rsp_ready_i && (q.size() > 0);
        e.err  = !m_ok(req_addr_i);
        e.inst = e.err ? NOP : mmem[req_addr_i[11:2]];
        @(posedge clk_i);
        if (pop) q.delete(0);
        if (acc) q.push_back(e);
        if (wr_en_i && m_ok(wr_addr_i)) mmem[wr_addr_i[11:2]] = wr_data_i;
        @(negedge clk_i);
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        req_valid_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        cycle();
        wr_en_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        wr_en_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = a;
        cycle();
        req_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] inst, input logic err);
        chk({tag, "_valid"}, rsp_valid_o, 1);
        chk({tag, "_inst"}, rsp_inst_o, inst);
        chk({tag, "_err"}, rsp_err_o, err);
    endtask

    initial begin
        rst_n_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b1;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_inst", rsp_inst_o, 0);
        chk("rst_err", rsp_err_o, 0);
        rst_n_i = 1'b1;
        #1;
        chk("rst_ready", req_ready_o, 1);
        @(negedge clk_i);

        // Load two words and fetch them back.
        write(32'h0, 32'h0050_0093);
        write(32'h4, 32'h0010_8113);
        fetch(32'h0); expect_rsp("load0", 32'h0050_0093, 0);
        fetch(32'h4); expect_rsp("load1", 32'h0010_8113, 0);
        cycle();

        // Fill words 2..63; word 2 gets a known pattern for the collision step.
        for (int i = 2; i < 64; i++) write(i * 4, (i == 2) ? 32'hAAAA_AAAA : $urandom());

        // Streaming: one response per cycle, no bubbles.
        for (int i = 0; i < 16; i++) begin
            fetch(i * 4);
            chk("stream_valid", rsp_valid_o, 1);
            chk("stream_ready", req_ready_o, 1);
        end
        cycle();

        // Backpressure: two accepted, third held off until after the first pop.
        rsp_ready_i = 1'b0;
        fetch(32'h10);
        fetch(32'h14);
        req_valid_i = 1'b1; req_addr_i = 32'h18;
        cycle();
        chk("bp_ready_low", req_ready_o, 0);
        chk("bp_head0", rsp_inst_o, mmem[4]);
        cycle();
        chk("bp_head1", rsp_inst_o, mmem[4]);
        rsp_ready_i = 1'b1;
        cycle();
        chk("bp_ready_after_pop", req_ready_o, 1);
        expect_rsp("bp_order", mmem[5], 0);
        cycle();
        req_valid_i = 1'b0;
        expect_rsp("bp_third", mmem[6], 0);
        repeat (2) cycle();

        // Error responses.
        fetch(32'h2);         expect_rsp("err_misaligned", NOP, 1);
        fetch(32'h1000);      expect_rsp("err_range", NOP, 1);
        fetch(32'hFFFF_FFFC); expect_rsp("err_top", NOP, 1);
        cycle();

        // Non-zero base: clear both instances, then probe just below and at base.
        #1 rst_n_i = 1'b0;
        #1 rst_n_i = 1'b1;
        q.delete();
        @(negedge clk_i);
        write(32'h100, 32'h1234_5678);
        fetch(32'h0FC);
        chk("base_below_valid", b_rsp_valid, 1);
        chk("base_below_inst", b_rsp_inst, NOP);
        chk("base_below_err", b_rsp_err, 1);
        fetch(32'h100);
        chk("base_at_valid", b_rsp_valid, 1);
        chk("base_at_inst", b_rsp_inst, 32'h1234_5678);
        chk("base_at_err", b_rsp_err, 0);
        cycle();

        // Same-edge write and fetch of one word.
        req_valid_i = 1'b1; req_addr_i = 32'h8;
        wr_en_i = 1'b1; wr_addr_i = 32'h8; wr_data_i = 32'hBBBB_BBBB;
        cycle();
        req_valid_i = 1'b0; wr_en_i = 1'b0;
        expect_rsp("coll_old", 32'hAAAA_AAAA, 0);
        fetch(32'h8);
        expect_rsp("coll_new", 32'hBBBB_BBBB, 0);
        cycle();

        // Reset between edges with two responses buffered.
        rsp_ready_i = 1'b0;
        fetch(32'h0);
        fetch(32'h4);
        chk("mid_full", req_ready_o, 0);
        #1 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid_o, 0);
        chk("mid_rst_inst", rsp_inst_o, 0);
        #1 rst_n_i = 1'b1;
        q.delete();
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        repeat (3) cycle();
        fetch(32'h4);
        cycle();

        // Randomized traffic with loader writes mixed in.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            req_valid_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7)       req_addr_i = $urandom_range(0, 64) * 4;
            else if (r == 7) req_addr_i = ($urandom_range(0, 64) * 4) | $urandom_range(1, 3);
            else if (r == 8) req_addr_i = 32'h1000 + $urandom_range(0, 100) * 4;
            else             req_addr_i = $urandom();
            wr_en_i   = ($urandom_range(0, 7) == 0);
            wr_addr_i = ($urandom_range(0, 64) * 4) | (($urandom_range(0, 5) == 0) ? 32'h1 : 32'h0);
            wr_data_i = $urandom();
            cycle();
        end
        req_valid_i = 1'b0; wr_en_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
